scan_sequencer: RTL and testbench

Upstream driver for the 2-to-4 decoder. It walks the decoder's 2-bit select (A1, A0) through the enabled output lines in ascending order, holding each line for a programmable number of cycles. Its enable output gates the decoder. Typical use is multiplexed LED or 7-segment digit scanning, where each decoder output lights one digit in turn.

---
 rtl/scan_sequencer.sv | 120 ++++++++++++
 tb/tb_scan_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Walks a 2-to-4 decoder select through the enabled lines in ascending order, dwell+1 cycles each.
// Optional macro SCAN_BLANK_EN inserts one enable-low BLANK cycle before every new address.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic               A1,
  output logic               A0,
  output logic               enable,
  output logic               busy,
  output logic               frame_done
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BLANK = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
`endif

  state_t             state;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [3:0]         mask_q;
  logic [1:0]         sel;
  logic               stop_pending;
  logic [1:0]         nxt_sel;
  logic               wrap;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) l = 2'(i);
    return l;
  endfunction

  // Next set bit strictly above the current address; otherwise wrap to the lowest set bit.
  always_comb begin
    nxt_sel = lowest(mask_q);
    wrap    = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel))) begin
        nxt_sel = 2'(i);
        wrap    = 1'b0;
      end
    end
  end

  assign A1 = sel[1];
  assign A0 = sel[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dwell_q      <= '0;
      cnt          <= '0;
      mask_q       <= '0;
      sel          <= 2'd0;
      stop_pending <= 1'b0;
      enable       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (mask != 4'd0)) begin
            dwell_q      <= dwell;
            mask_q       <= mask;
            sel          <= lowest(mask);
            cnt          <= '0;
            stop_pending <= 1'b0;
            enable       <= 1'b1;
            busy         <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == dwell_q) begin
            cnt <= '0;
            // A stop seen on the last cycle of the frame still ends this frame.
            if (wrap && (stop_pending || stop)) begin
              state        <= IDLE;
              sel          <= 2'd0;
              enable       <= 1'b0;
              busy         <= 1'b0;
              frame_done   <= 1'b1;
              stop_pending <= 1'b0;
            end else begin
              sel          <= nxt_sel;
              frame_done   <= wrap;
              stop_pending <= stop_pending | stop;
`ifdef SCAN_BLANK_EN
              enable       <= 1'b0;
              state        <= BLANK;
`endif
            end
          end else begin
            cnt          <= cnt + 1'b1;
            stop_pending <= stop_pending | stop;
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          enable       <= 1'b1;
          stop_pending <= stop_pending | stop;
          state        <= SCAN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; observed vector is {busy, enable, A1, A0, frame_done}.
module tb_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic       A1, A0, enable, busy, frame_done;
  int         tests = 0;
  int         fails = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell), .mask(mask),
    .A1(A1), .A0(A0), .enable(enable), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, enable, A1, A0, frame_done};
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] sv(input logic en, input int a, input logic fd);
    logic [1:0] a2;
    a2 = 2'(a);
    return {1'b1, en, a2, fd};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 8'd0; mask = 4'd0;
    tick(); tick();
    chk("reset", 5'b00000);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 5'b00000);

`ifdef SCAN_BLANK_EN
    // dwell=1, mask=0011: 00 en x2, 01 blank, 01 en x2, 00 blank + frame_done
    dwell = 8'd1; mask = 4'b0011; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      case (i % 6)
        0, 1:    chk("blank_pat", sv(1'b1, 0, 1'b0));
        2:       chk("blank_pat", sv(1'b0, 1, 1'b0));
        3, 4:    chk("blank_pat", sv(1'b1, 1, 1'b0));
        default: chk("blank_pat", sv(1'b0, 0, 1'b1));
      endcase
      stop = (i == 12);
      tick();
    end
    stop = 1'b0;
    for (int i = 13; i < 17; i++) begin
      case (i % 6)
        0, 1:    chk("blank_stop", sv(1'b1, 0, 1'b0));
        2:       chk("blank_stop", sv(1'b0, 1, 1'b0));
        default: chk("blank_stop", sv(1'b1, 1, 1'b0));
      endcase
      tick();
    end
    chk("blank_stop_done", 5'b00001);
    tick();
    chk("blank_idle", 5'b00000);
`else
    // dwell=2, mask=1111: each address 3 cycles, frame_done on return to 00
    dwell = 8'd2; mask = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      chk("full_scan", sv(1'b1, (i / 3) % 4, (i == 12) || (i == 24)));
      stop = (i == 24);
      tick();
    end
    stop = 1'b0;
    chk("full_stop_done", 5'b00001);
    tick();
    chk("full_idle", 5'b00000);

    // dwell=0, mask=1010: alternate 01/11; stop on final cycle of a frame ends it
    dwell = 8'd0; mask = 4'b1010; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("dwell0", sv(1'b1, (i % 2) ? 3 : 1, (i > 0) && (i % 2 == 0)));
      stop = (i == 9);
      tick();
    end
    stop = 1'b0;
    chk("dwell0_stop_done", 5'b00001);
    tick();
    chk("dwell0_idle", 5'b00000);

    // dwell=1, mask=1111, stop at 01; start with new settings while busy is ignored
    dwell = 8'd1; mask = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("stop_mid", sv(1'b1, i / 2, 1'b0));
      stop = (i == 2);
      start = (i == 4);
      if (i == 4) begin dwell = 8'd5; mask = 4'b0100; end
      tick();
    end
    stop = 1'b0; start = 1'b0;
    chk("stop_mid_done", 5'b00001);
    tick();
    chk("stop_mid_idle", 5'b00000);

    // mask=0 start is ignored
    mask = 4'b0000; start = 1'b1;
    tick();
    chk("mask0_a", 5'b00000);
    tick(); start = 1'b0;
    chk("mask0_b", 5'b00000);

    // single-bit mask: address fixed at 11, frame_done every dwell+1 cycles
    dwell = 8'd1; mask = 4'b1000; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("single_bit", sv(1'b1, 3, (i == 2) || (i == 4)));
      stop = (i == 4);
      tick();
    end
    stop = 1'b0;
    chk("single_stop_done", 5'b00001);
    tick();

    // async reset mid-dwell at address 10, then restart from lowest bit
    dwell = 8'd3; mask = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_addr10", sv(1'b1, 2, 1'b0));
    #3 rst = 1'b1;
    #1 chk("async_rst", 5'b00000);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 5'b00000);
    mask = 4'b0110; dwell = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("restart_low", sv(1'b1, 1, 1'b0));
    tick();
    chk("restart_next", sv(1'b1, 2, 1'b0));
    tick();
    chk("restart_wrap", sv(1'b1, 1, 1'b1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
